// File: rtl/inst_mem_resp.sv
// inst_mem_resp: instruction memory responder with wait states, stall request and loader port
module inst_mem_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           addr_i,
  output logic [31:0]           data_o,
  output logic                  ready_o,
  output logic                  stallreq_o,
  output logic                  err_o,
  input  logic                  ld_we_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [31:0]           ld_data_i
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [2:0] CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
  state_t state_q, state_d;
  logic valid_q, valid_d, err_q, err_d;
  logic [31:0] held_q, held_d, data_q, data_d;
  logic [2:0] cnt_q, cnt_d;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word;
  logic same, hit, oor, mis, ld_held, ld_cur, miss, done;
  assign word       = addr_i[ADDR_WIDTH+1:2];
  assign same       = addr_i == held_q;
  assign hit        = valid_q && same;
  assign oor        = |addr_i[31:ADDR_WIDTH+2];
  assign mis        = |addr_i[1:0];
  assign ld_held    = ld_we_i && ld_addr_i == held_q[ADDR_WIDTH+1:2];
  assign ld_cur     = ld_we_i && ld_addr_i == word;
  assign ready_o    = ce_i && hit;
  assign stallreq_o = ce_i && !hit;
  assign data_o     = data_q;
  assign err_o      = err_q;
  // loader writes; array survives reset
  always_ff @(posedge clk)
    if (ld_we_i) mem[ld_addr_i] <= ld_data_i;
  // state register
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // next state: a loader hit on the held word keeps BUSY alive so fresh data is returned
  always_comb
    state_d = (state_q == IDLE)
      ? ((ce_i && !hit && WAIT_CYCLES != 0) ? BUSY : IDLE)
      : ((!ce_i || !same || (cnt_q == 3'd0 && !ld_held)) ? IDLE : BUSY);
  // access datapath: latch miss address, count wait states, complete the read
  always_comb begin
    miss    = state_q == IDLE && ce_i && !hit;
    done    = (miss && WAIT_CYCLES == 0) ||
              (state_q == BUSY && ce_i && same && cnt_q == 3'd0 && !ld_held);
    held_d  = miss ? addr_i : held_q;
    data_d  = done ? (oor ? 32'h0 : mem[word]) : data_q;
    err_d   = done && (oor || mis);
    valid_d = done ? !ld_cur : (miss || ld_held) ? 1'b0 : valid_q;
    cnt_d   = miss ? CNT_INIT
            : (state_q == BUSY && ld_held) ? CNT_INIT
            : (state_q == BUSY && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
  end
  // datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      valid_q <= 1'b0;
      held_q  <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      valid_q <= valid_d;
      held_q  <= held_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed scoreboard bench over four wait-state configurations
module tb_inst_mem_resp;
  localparam logic [31:0] M0 = 32'hA000_0000, M1 = 32'hA111_1111, M2 = 32'hA222_2222, M4 = 32'h3401_0020;
  logic clk = 0, rst = 1;
  logic ce [4], rdy [4], stall [4], err [4], ld_we [4];
  logic [31:0] addr [4], dout [4], ld_data [4];
  logic [9:0] ld_addr [4];
  logic [31:0] sbq [$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    inst_mem_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 5)) u (
      .clk(clk), .rst(rst), .ce_i(ce[g]), .addr_i(addr[g]), .data_o(dout[g]),
      .ready_o(rdy[g]), .stallreq_o(stall[g]), .err_o(err[g]),
      .ld_we_i(ld_we[g]), .ld_addr_i(ld_addr[g]), .ld_data_i(ld_data[g]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic load_all(input logic [9:0] wa, input logic [31:0] d);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin ld_we[i] = 1; ld_addr[i] = wa; ld_data[i] = d; end
  endtask
  task automatic fetch(input int i, input logic [31:0] a, input logic [31:0] exp,
                       input logic experr, input int stalls);
    int n = 0;
    @(negedge clk);
    ce[i] = 1; addr[i] = a; ld_we[i] = 0;
    sbq.push_back(exp);
    #1;
    while (!rdy[i] && n < 40) begin
      chk("stallreq", 32'(stall[i]), 1);
      n++;
      @(negedge clk); #1;
    end
    chk("latency", n, stalls);
    chk("data", dout[i], sbq.pop_front());
    chk("err_pulse", 32'(err[i]), 32'(experr));
    @(negedge clk); #1;
    chk("rehit", 32'(rdy[i]), 1);
    chk("err_clear", 32'(err[i]), 0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      ce[i] = 0; addr[i] = 0; ld_we[i] = 0; ld_addr[i] = 0; ld_data[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 0; #1;
    chk("rst_data", dout[0], 0);
    chk("rst_err", 32'(err[0]), 0);
    chk("rst_ready", 32'(rdy[0]), 0);
    chk("rst_stall", 32'(stall[0]), 0);
    load_all(10'd0, M0);
    load_all(10'd1, M1);
    load_all(10'd2, M2);
    load_all(10'd4, M4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) ld_we[i] = 0;
    fetch(0, 32'h10, M4, 0, 2);
    fetch(1, 32'h0, M0, 0, 1);
    fetch(1, 32'h4, M1, 0, 1);
    fetch(1, 32'h8, M2, 0, 1);
    @(negedge clk); ce[2] = 1; addr[2] = 32'h0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("abort_nostale", dout[2], 0);
    fetch(2, 32'h4, M1, 0, 5);
    fetch(0, 32'h0000_1000, 32'h0, 1, 2);
    fetch(0, 32'h2, M0, 1, 2);
    fetch(0, 32'h8, M2, 0, 2);
    @(negedge clk);
    ld_we[0] = 1; ld_addr[0] = 10'd2; ld_data[0] = 32'hDEAD_BEEF; #1;
    chk("pre_inval_ready", 32'(rdy[0]), 1);
    fetch(0, 32'h8, 32'hDEAD_BEEF, 0, 2);
    fetch(3, 32'h0, M0, 0, 6);
    @(negedge clk); addr[3] = 32'h4;
    @(negedge clk);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; ce[3] = 0; #1;
    chk("rst_mid_data", dout[3], 0);
    chk("rst_mid_ready", 32'(rdy[3]), 0);
    chk("rst_mid_err", 32'(err[3]), 0);
    chk("rst_mid_stall", 32'(stall[3]), 0);
    fetch(3, 32'h4, M1, 0, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
